// File: rtl/card_deck_shuffler_if.sv
// card_deck_shuffler_if: draw/shuffle request and card delivery bundle between game FSM and deck
//   i_draw, i_shuffle : requests from the game FSM (master)
//   o_card            : dealt card {suit[5:4], rank[3:0]}
//   o_card_valid      : one-cycle pulse qualifying o_card
//   o_ready           : deck idle and accepting requests
//   o_remaining       : cards not yet dealt, 0..52
//   o_empty           : o_remaining == 0
//   o_draw_error      : one-cycle pulse, draw requested on an empty deck
interface card_deck_shuffler_if;
    logic       i_draw;
    logic       i_shuffle;
    logic [5:0] o_card;
    logic       o_card_valid;
    logic       o_ready;
    logic [5:0] o_remaining;
    logic       o_empty;
    logic       o_draw_error;
    modport master (
        output i_draw, i_shuffle,
        input  o_card, o_card_valid, o_ready, o_remaining, o_empty, o_draw_error
    );
    modport slave (
        input  i_draw, i_shuffle,
        output o_card, o_card_valid, o_ready, o_remaining, o_empty, o_draw_error
    );
endinterface

// File: rtl/card_deck_shuffler.sv
// card_deck_shuffler: 52-card deck with LFSR-driven Fisher-Yates shuffle, deals one card per draw
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset, restarts from deck initialisation
//   bus     : card_deck_shuffler_if.slave (draw/shuffle requests, card and status outputs)
module card_deck_shuffler #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          SHUFFLE_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    card_deck_shuffler_if.slave  bus
);
    typedef enum logic [1:0] {S_INIT, S_SHUFFLE, S_READY} state_t;
    state_t      state, nextState;
    logic [5:0]  deck [52];
    logic [5:0]  idx, ptr, j, initCode;
    logic [15:0] lfsr;
    logic        isReady, drawReq, shuffleReq, initDone, shuffleHit, shuffleDone, haveCard;
    assign j           = lfsr[5:0];
    assign isReady     = state == S_READY;
    // shuffle has priority over a simultaneous draw
    assign shuffleReq  = isReady && bus.i_shuffle;
    assign drawReq     = isReady && bus.i_draw && !bus.i_shuffle;
    assign haveCard    = ptr < 6'd52;
    assign initDone    = state == S_INIT && idx == 6'd51;
    // rejection sampling: candidates above the current index are discarded
    assign shuffleHit  = state == S_SHUFFLE && j <= idx;
    assign shuffleDone = shuffleHit && idx == 6'd1;
    assign initCode    = {2'(idx / 6'd13), 4'(idx % 6'd13 + 6'd1)};
    always_comb begin
        nextState = initDone    ? (SHUFFLE_EN ? S_SHUFFLE : S_READY) :
                    shuffleDone ? S_READY :
                    shuffleReq  ? S_SHUFFLE : state;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_INIT;
        else         state <= nextState;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx              <= '0;
            ptr              <= '0;
            lfsr             <= LFSR_SEED;
            bus.o_card       <= '0;
            bus.o_card_valid <= 1'b0;
            bus.o_draw_error <= 1'b0;
        end else begin
            // free-running so request timing perturbs the shuffle
            lfsr             <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            bus.o_card_valid <= drawReq && haveCard;
            bus.o_draw_error <= drawReq && !haveCard;
            if (drawReq && haveCard) begin
                bus.o_card <= deck[ptr];
                ptr        <= ptr + 6'd1;
            end
            if (state == S_INIT && !initDone) idx <= idx + 6'd1;
            if (shuffleHit) idx <= idx - 6'd1;
            if (shuffleReq) idx <= 6'd51;
            if (nextState == S_READY && !isReady) ptr <= '0;
        end
    end
    // array carries no reset: initialisation rewrites every entry after reset
    always_ff @(posedge i_clk) begin
        if (state == S_INIT) deck[idx] <= initCode;
        if (shuffleHit) begin
            deck[idx] <= deck[j];
            deck[j]   <= deck[idx];
        end
    end
    assign bus.o_ready     = isReady;
    assign bus.o_remaining = isReady ? 6'd52 - ptr : 6'd0;
    assign bus.o_empty     = bus.o_remaining == 6'd0;
endmodule

// File: doc/card_deck_shuffler.md
Name: card_deck_shuffler

Overview:
- Upstream card source for the blackjack game FSM and the two hand controllers.
- Holds one 52-card deck, shuffles it in hardware (Fisher-Yates driven by a free-running LFSR), and deals one card per accepted draw request.
- The game FSM consumes o_card/o_card_valid and forwards each card to the player or dealer hand, and uses o_ready/o_remaining to pace the deal.

Parameters:
- LFSR_SEED, 16'hACE1: non-zero LFSR reset value.
- SHUFFLE_EN, 1: 0 = skip shuffle and deal in init order (bench/debug).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_draw  in  1  request one card; honoured only while o_ready=1
- i_shuffle  in  1  request return of all 52 cards and reshuffle; honoured only while o_ready=1
- o_card  out  6  dealt card {suit[5:4], rank[3:0]}; rank 1..13 (1=A, 11-13=J/Q/K); suit 0..3
- o_card_valid  out  1  one-cycle pulse; o_card is valid this cycle
- o_ready  out  1  deck idle and accepting draw/shuffle
- o_remaining  out  6  cards not yet dealt, 0..52
- o_empty  out  1  o_remaining==0
- o_draw_error  out  1  one-cycle pulse: draw requested while empty

Behaviour:
- Storage: 52 x 6-bit register array deck[0..51]; deal pointer ptr (6 bits); o_card registered.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Steps every clock from reset regardless of state, so draw timing adds entropy.
- Reset (async): state=S_INIT, ptr=0, i=0, LFSR=LFSR_SEED. Outputs: o_card=0, o_card_valid=0, o_ready=0, o_remaining=0, o_empty=1, o_draw_error=0.
- States:
  - S_INIT: one entry per cycle, deck[i] = {i/13, i%13+1}, i=0..51 (52 cycles). Then i=51; go to S_SHUFFLE if SHUFFLE_EN, else S_READY.
  - S_SHUFFLE:
    - Each cycle, candidate j = lfsr[5:0].
    - If j<=i: swap deck[i] and deck[j] in the same cycle, then i=i-1.
    - Else reject; no change to the array; retry next cycle.
    - After the i=1 swap, go to S_READY.
  - S_READY:
    - ptr=0 on entry; o_ready=1; o_remaining = 52-ptr; o_empty = (ptr==52).
- Draw (S_READY, i_draw=1, i_shuffle=0):
  - ptr<52: next cycle o_card=deck[ptr], o_card_valid=1, ptr++. o_remaining decrements in the same cycle o_card_valid rises. Latency 1 clock. Back-to-back draws give one card per cycle.
  - ptr==52: no card; o_draw_error=1 for the next cycle; o_card holds its last value.
- Shuffle (S_READY, i_shuffle=1):
  - Next cycle enters S_SHUFFLE with i=51 over the current array contents; no re-init.
  - o_ready=0, o_remaining=0, o_empty=1 until S_READY is re-entered.
  - ptr resets to 0 on re-entry.
- Simultaneous i_draw and i_shuffle: shuffle wins; draw dropped, no valid, no error.
- i_draw/i_shuffle while o_ready=0: ignored, no error.
- Reset mid-shuffle or mid-deal: full restart from S_INIT; partial deal discarded.
- Invariant: the array is always a permutation of the 52 codes; swaps never duplicate or lose a card.
- o_card_valid and o_draw_error are never high in the same cycle.
- Codes rank 0, 14, 15 are never produced.

Test Plan:
- SHUFFLE_EN=0, reset, wait for o_ready, 52 back-to-back draws -> cards in order {0,1},{0,2}..{0,13},{1,1}..{3,13}; o_remaining 51..0; o_empty=1 after the last card.
- SHUFFLE_EN=1, after o_ready, 52 draws -> each of the 52 codes appears exactly once; order differs from init order; each o_card_valid arrives 1 cycle after its i_draw.
- Deck empty, i_draw=1 -> o_draw_error pulses 1 cycle, o_card_valid=0, o_remaining stays 0.
- Draw 10 cards, assert i_shuffle and i_draw together -> no card dealt; o_ready drops; after reshuffle o_remaining=52; the next 52 draws are again a full permutation.
- Assert i_reset during S_SHUFFLE and during S_READY with ptr=20 -> all outputs return to reset values immediately; the deal restarts from S_INIT with o_remaining=52 once o_ready rises.
- i_draw held high while o_ready=0 (S_INIT/S_SHUFFLE) -> no o_card_valid and no o_draw_error until S_READY is entered.
